// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-7-segment table for the 4-digit scan controller.
package seg7_pkg;

    typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_t;

    localparam int unsigned NUM_DIGITS = 4;

    // Active-low cathodes, bit order gfedcba.
    localparam logic [6:0] HEX7_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7_LUT[hex_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-seg display.
// Define SEG7_LZB_EN to enable leading-zero blanking of digits 1..3.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seg_data,
    input  logic        seg_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned CntW = $clog2(DIGIT_CYCLES);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] SlotLast  = CntW'(DIGIT_CYCLES - 1);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_params
        $error("seg7_scan_ctrl: need 1 <= BLANK_CYCLES < DIGIT_CYCLES");
    end

    scan_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [15:0]     shadow_q, shadow_d;
    logic            started_q;
    logic [3:0]      an_d;
    logic [6:0]      seg_d;
    logic            tick_d;
    logic [3:0]      nibble;
    logic [6:0]      hex_seg;
    logic            digit_on;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        digit_d = digit_q;
        tick_d  = 1'b0;
        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == BlankLast) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (cnt_q == SlotLast) begin
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                    state_d = ST_BLANK;
                    tick_d  = (digit_q == 2'd3);
                end
            end
        endcase
        // Latch a new frame on the first edge after reset and on every 3->0 wrap.
        shadow_d = (!started_q || tick_d) ? seg_data : shadow_q;
    end

    assign nibble = shadow_d[{digit_d, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .hex_i (nibble),
        .seg_o (hex_seg)
    );

`ifdef SEG7_LZB_EN
    always_comb begin
        digit_on = 1'b1;
        case (digit_d)
            2'd1:    digit_on = |shadow_d[15:4];
            2'd2:    digit_on = |shadow_d[15:8];
            2'd3:    digit_on = |shadow_d[15:12];
            default: digit_on = 1'b1;
        endcase
    end
`else
    assign digit_on = 1'b1;
`endif

    // Outputs are decoded from next-state so the pins line up with the state register.
    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        if (state_d == ST_DRIVE) begin
            seg_d = hex_seg;
            if (seg_en && digit_on) an_d[digit_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            digit_q    <= 2'd0;
            shadow_q   <= 16'h0000;
            started_q  <= 1'b0;
            an         <= 4'hF;
            seg        <= 7'h7F;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            shadow_q   <= shadow_d;
            started_q  <= 1'b1;
            an         <= an_d;
            seg        <= seg_d;
            frame_tick <= tick_d;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with a slot/frame arithmetic reference model.
module tb_seg7_scan_ctrl;

    localparam int D     = 10;
    localparam int B     = 2;
    localparam int FRAME = 4 * D;

    logic        clk;
    logic        reset;
    logic [15:0] seg_data;
    logic        seg_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seg7_scan_ctrl #(
        .DIGIT_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_data   (seg_data),
        .seg_en     (seg_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic       seg_chk;
        logic       tick;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          passes = 0;
    int          k = 0;
    logic [15:0] shadow_m = 16'h0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] hex_ref(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] got,
                         input logic [15:0] exp_v);
        checks++;
        if (got === exp_v) passes++;
        else $display("FAIL %s at k=%0d: got %h, expected %h", name, idx, got, exp_v);
    endtask

    // Reference model: cycle k after reset release lies in slot k/D, position k%D.
    initial begin
        exp_t e;
        int   pos;
        int   digit;
        logic lit;
        forever begin
            @(posedge clk);
            if (!reset) begin
                k++;
                if (k == 1 || k % FRAME == 0) shadow_m = seg_data;
                pos       = k % D;
                digit     = (k / D) % 4;
                e.k       = k;
                e.an      = 4'hF;
                e.seg     = 7'h7F;
                e.seg_chk = 1'b1;
                e.tick    = (k % FRAME == 0);
                if (pos >= B) begin
                    e.seg = hex_ref(4'((shadow_m >> (4 * digit)) & 16'hF));
`ifdef SEG7_LZB_EN
                    lit = seg_en && (digit == 0 || (shadow_m >> (4 * digit)) != 0);
`else
                    lit = seg_en;
`endif
                    if (lit) e.an = ~(4'b0001 << digit);
                    else     e.seg_chk = 1'b0;
                end
                q.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(posedge reset);
            k = 0;
            q.delete();
        end
    end

    // Monitor: every clocked cycle is an output presentation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("an", e.k, {12'h0, an}, {12'h0, e.an});
                check("frame_tick", e.k, {15'h0, frame_tick}, {15'h0, e.tick});
                check("dp", e.k, {15'h0, dp}, 16'h0001);
                if (e.seg_chk) check("seg", e.k, {9'h0, seg}, {9'h0, e.seg});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        seg_data = 16'h1234;
        seg_en   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("reset_an", 0, {12'h0, an}, 16'h000F);
            check("reset_seg", 0, {9'h0, seg}, 16'h007F);
            check("reset_dp", 0, {15'h0, dp}, 16'h0001);
            check("reset_tick", 0, {15'h0, frame_tick}, 16'h0000);
        end
        reset = 1'b0;

        // Mid-frame change during digit 1 of frame 1 must not tear.
        cycles(55);
        seg_data = 16'hABCD;
        // Drop enable in digit 2 drive of frame 2, then restore.
        cycles(50);
        seg_en = 1'b0;
        cycles(2);
        seg_en = 1'b1;
        cycles(66);

        // Async reset pulse mid-drive, with no clock edge in between.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_an", k, {12'h0, an}, 16'h000F);
        check("async_seg", k, {9'h0, seg}, 16'h007F);
        check("async_tick", k, {15'h0, frame_tick}, 16'h0000);
        cycles(2);
        reset = 1'b0;
        cycles(90);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(19) == 0) seg_data = 16'($urandom);
            if ($urandom_range(14) == 0) seg_en = ~seg_en;
        end

        seg_en   = 1'b1;
        seg_data = 16'h0005;
        cycles(90);
        seg_data = 16'h0000;
        cycles(90);
        seg_data = 16'h0300;
        cycles(90);

        @(negedge clk);
        check("queue_drained", k, 16'(q.size()), 16'h0000);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
